// File: rtl/dc_ipu_pixel_sink.sv
// dc_ipu_pixel_sink: first-word-fall-through output FIFO that tags
// filtered pixels with sof/eol/eof from latched frame dimensions.
module dc_ipu_pixel_sink #(
  parameter int COLOR_WIDTH = 8,
  parameter int DEPTH       = 16,
  parameter int DIM_WIDTH   = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DIM_WIDTH-1:0]     cfg_width,
  input  logic [DIM_WIDTH-1:0]     cfg_height,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3*COLOR_WIDTH-1:0] in_pixel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3*COLOR_WIDTH-1:0] out_pixel,
  output logic                     out_sof,
  output logic                     out_eol,
  output logic                     out_eof,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frame_done,
  output logic                     cfg_err
);

  localparam int PW = 3 * COLOR_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = PW + 3;
  localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [EW-1:0]        mem [DEPTH];
  logic [EW-1:0]        head;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          level_q;
  logic [DIM_WIDTH-1:0] w_q, h_q;
  logic [DIM_WIDTH-1:0] w_m1, h_m1;
  logic [DIM_WIDTH-1:0] x_q, y_q, x_d, y_d;
  logic                 frame_done_q;
  logic                 full, push, pop;
  logic                 tag_sof, tag_eol, tag_eof;

  assign w_m1 = w_q - 1'b1;
  assign h_m1 = h_q - 1'b1;

  assign full      = (level_q == LVL_FULL);
  assign out_valid = (level_q != '0);
  assign cfg_err   = (state_q == IDLE) && ((w_q == '0) || (h_q == '0));

  // Hold input off while the frame_done pulse of the previous frame is out
  assign in_ready = ~full & ~cfg_err &
                    ~((state_q == IDLE) & frame_done_q);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign head = mem[rd_ptr];
  assign {out_eof, out_eol, out_sof, out_pixel} = out_valid ? head : '0;

  assign level      = level_q;
  assign frame_done = frame_done_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    tag_sof = (state_q == IDLE);
    tag_eol = (x_q == w_m1);
    tag_eof = tag_eol && (y_q == h_m1);
    if (push) begin
      if (tag_eof) begin
        x_d     = '0;
        y_d     = '0;
        state_d = IDLE;
      end else if (tag_eol) begin
        x_d     = '0;
        y_d     = y_q + 1'b1;
        state_d = RUN;
      end else begin
        x_d     = x_q + 1'b1;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {tag_eof, tag_eol, tag_sof, in_pixel};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= '0;
      h_q          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      if (state_q == IDLE) begin
        w_q <= cfg_width;
        h_q <= cfg_height;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      frame_done_q <= pop & head[EW-1];
    end
  end

endmodule

// File: tb/tb_dc_ipu_pixel_sink.sv
// tb_dc_ipu_pixel_sink: randomized bench for dc_ipu_pixel_sink with a
// queue-based frame-position reference model.
module tb_dc_ipu_pixel_sink;

  localparam int DEPTH = 16;
  localparam int DW    = 12;
  localparam int PW    = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] cfg_width, cfg_height;
  logic          in_valid, in_ready;
  logic [PW-1:0] in_pixel;
  logic          out_valid, out_ready;
  logic [PW-1:0] out_pixel;
  logic          out_sof, out_eol, out_eof;
  logic [4:0]    level;
  logic          frame_done, cfg_err;

  always #5 clk = ~clk;

  dc_ipu_pixel_sink #(
    .COLOR_WIDTH(8),
    .DEPTH(DEPTH),
    .DIM_WIDTH(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_width(cfg_width),
    .cfg_height(cfg_height),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pixel(in_pixel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pixel(out_pixel),
    .out_sof(out_sof),
    .out_eol(out_eol),
    .out_eof(out_eof),
    .level(level),
    .frame_done(frame_done),
    .cfg_err(cfg_err)
  );

  int checks = 0;
  int errors = 0;

  // entry layout: {eof, eol, sof, pixel}
  logic [26:0] fifo_m[$];
  logic [26:0] got_q[$];
  logic [26:0] want_q[$];
  int          n_pos, fw, fh;
  logic [DW-1:0] lat_w, lat_h;
  bit          fd_m;
  int          pushes, pops, fd_seen, fd_exp, max_lvl;
  int          rdy_mis, lvl_mis, fd_mis;
  bit          m_push, m_pop, m_pop_eof;
  logic [PW-1:0] last_pix;

  task automatic clear_model();
    fifo_m.delete();
    got_q.delete();
    want_q.delete();
    n_pos = 0; fw = 0; fh = 0;
    lat_w = '0; lat_h = '0;
    fd_m = 0;
    pushes = 0; pops = 0; fd_seen = 0; fd_exp = 0; max_lvl = 0;
    rdy_mis = 0; lvl_mis = 0; fd_mis = 0;
    m_push = 0; m_pop = 0; m_pop_eof = 0;
  endtask

  // One clock: model predicts handshakes from frame position and queue size
  task automatic cyc();
    bit idle, exp_rdy, fd_next, s, l, f;
    int sz;
    logic [26:0] e;
    @(negedge clk);
    sz = fifo_m.size();
    idle = (n_pos == 0);
    exp_rdy = (sz < DEPTH) && !(idle && (lat_w == 0 || lat_h == 0))
              && !(idle && fd_m);
    if (in_ready !== exp_rdy) rdy_mis++;
    if (int'(level) != sz || out_valid !== (sz != 0)) lvl_mis++;
    if (frame_done !== fd_m) fd_mis++;
    if (frame_done === 1'b1) fd_seen++;
    if (int'(level) > max_lvl) max_lvl = int'(level);
    m_push = in_valid && exp_rdy;
    m_pop = out_ready && (sz != 0);
    m_pop_eof = 0;
    fd_next = 0;
    if (m_pop) begin
      got_q.push_back({out_eof, out_eol, out_sof, out_pixel});
      e = fifo_m.pop_front();
      want_q.push_back(e);
      fd_next = e[26];
      m_pop_eof = e[26];
      pops++;
    end
    if (m_push) begin
      if (n_pos == 0) begin
        fw = int'(lat_w);
        fh = int'(lat_h);
      end
      s = (n_pos == 0);
      l = ((n_pos + 1) % fw) == 0;
      f = (n_pos + 1) == fw * fh;
      fifo_m.push_back({f, l, s, in_pixel});
      last_pix = in_pixel;
      pushes++;
      n_pos = f ? 0 : n_pos + 1;
    end
    if (idle) begin
      lat_w = cfg_width;
      lat_h = cfg_height;
    end
    if (fd_next) fd_exp++;
    @(posedge clk);
    fd_m = fd_next;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_pixel = 24'h123456;
    cfg_width = 12'd4;
    cfg_height = 12'd2;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (level !== 5'd0) begin
      errors++; $display("FAIL reset_level got %0d want 0", level);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got %b want 0", in_ready);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_frame_done got %b want 0", frame_done);
    end
    checks++;
    if ({out_eof, out_eol, out_sof, out_pixel} !== 27'd0) begin
      errors++;
      $display("FAIL reset_head got %h want 0",
               {out_eof, out_eol, out_sof, out_pixel});
    end
    reset = 1'b0;
    in_valid = 1'b0;
    clear_model();
    cyc();
    checks++;
    if (in_ready !== 1'b1 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_ready got rdy=%b err=%b want rdy=1 err=0",
               in_ready, cfg_err);
    end
  endtask

  task automatic test_basic();
    int guard;
    logic [26:0] ex;
    cfg_width = 12'd4;
    cfg_height = 12'd2;
    do_reset();
    out_ready = 1'b1;
    guard = 0;
    while ((pushes < 8 || pops < 8) && guard < 200) begin
      in_valid = (pushes < 8);
      in_pixel = 24'(pushes + 1);
      cyc();
      guard++;
      if (m_push) begin
        checks++;
        if (out_valid !== 1'b1 || out_pixel !== last_pix) begin
          errors++;
          $display("FAIL basic_latency got v=%b px=%h want v=1 px=%h",
                   out_valid, out_pixel, last_pix);
        end
      end
      if (m_pop_eof) begin
        checks++;
        if (frame_done !== 1'b1) begin
          errors++; $display("FAIL basic_fd_pulse got %b want 1", frame_done);
        end
      end
    end
    in_valid = 1'b0;
    cyc();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL basic_fd_width got %b want 0", frame_done);
    end
    checks++;
    if (got_q.size() != 8) begin
      errors++; $display("FAIL basic_count got %0d want 8", got_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        ex = {i == 7, i % 4 == 3, i == 0, 24'(i + 1)};
        checks++;
        if (got_q[i] !== ex) begin
          errors++;
          $display("FAIL basic_entry%0d got %h want %h", i, got_q[i], ex);
        end
      end
    end
    checks++;
    if (fd_seen != 1) begin
      errors++; $display("FAIL basic_fd_count got %0d want 1", fd_seen);
    end
  endtask

  task automatic test_full();
    int guard;
    cfg_width = 12'd8;
    cfg_height = 12'd8;
    do_reset();
    out_ready = 1'b0;
    repeat (20) begin
      in_valid = 1'b1;
      in_pixel = 24'($urandom);
      cyc();
    end
    checks++;
    if (pushes != 16 || level !== 5'd16 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_fill got push=%0d lvl=%0d rdy=%b want 16 16 0",
               pushes, level, in_ready);
    end
    out_ready = 1'b1;
    cyc();
    checks++;
    if (level !== 5'd15 || pushes != 16) begin
      errors++;
      $display("FAIL full_pop got lvl=%0d push=%0d want lvl=15 push=16",
               level, pushes);
    end
    in_valid = 1'b0;
    guard = 0;
    while (pops < 16 && guard < 100) begin
      cyc();
      guard++;
    end
    checks++;
    if (got_q.size() != 16) begin
      errors++; $display("FAIL full_drain got %0d want 16", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== want_q[i]) begin
        errors++;
        $display("FAIL full_order%0d got %h want %h", i, got_q[i], want_q[i]);
      end
    end
    checks++;
    if (rdy_mis != 0 || lvl_mis != 0) begin
      errors++;
      $display("FAIL full_track got rdy_mis=%0d lvl_mis=%0d want 0 0",
               rdy_mis, lvl_mis);
    end
  endtask

  task automatic test_random();
    int guard, n_sof, n_eol, n_eof;
    cfg_width = 12'd7;
    cfg_height = 12'd5;
    do_reset();
    guard = 0;
    while (pops < 105 && guard < 5000) begin
      in_valid = (pushes < 105) && ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 1) == 1);
      in_pixel = 24'($urandom);
      cyc();
      guard++;
    end
    in_valid = 1'b0;
    repeat (2) cyc();
    checks++;
    if (got_q.size() != 105) begin
      errors++; $display("FAIL rand_count got %0d want 105", got_q.size());
    end
    n_sof = 0; n_eol = 0; n_eof = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      n_sof += int'(got_q[i][24]);
      n_eol += int'(got_q[i][25]);
      n_eof += int'(got_q[i][26]);
      checks++;
      if (got_q[i] !== want_q[i]) begin
        errors++;
        $display("FAIL rand_entry%0d got %h want %h", i, got_q[i], want_q[i]);
      end
    end
    checks++;
    if (n_sof != 3 || n_eol != 15 || n_eof != 3) begin
      errors++;
      $display("FAIL rand_flags got sof=%0d eol=%0d eof=%0d want 3 15 3",
               n_sof, n_eol, n_eof);
    end
    checks++;
    if (fd_seen != 3) begin
      errors++; $display("FAIL rand_fd got %0d want 3", fd_seen);
    end
    checks++;
    if (max_lvl > 16) begin
      errors++; $display("FAIL rand_maxlvl got %0d want <=16", max_lvl);
    end
    checks++;
    if (rdy_mis != 0 || lvl_mis != 0 || fd_mis != 0) begin
      errors++;
      $display("FAIL rand_track got rdy=%0d lvl=%0d fd=%0d want 0 0 0",
               rdy_mis, lvl_mis, fd_mis);
    end
  endtask

  task automatic test_unit_frame();
    int guard;
    cfg_width = 12'd1;
    cfg_height = 12'd1;
    do_reset();
    out_ready = 1'b1;
    guard = 0;
    while (pops < 3 && guard < 100) begin
      in_valid = (pushes < 3);
      in_pixel = 24'($urandom);
      cyc();
      guard++;
    end
    in_valid = 1'b0;
    repeat (2) cyc();
    checks++;
    if (got_q.size() != 3) begin
      errors++; $display("FAIL unit_count got %0d want 3", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i][26:24] !== 3'b111 || got_q[i] !== want_q[i]) begin
        errors++;
        $display("FAIL unit_entry%0d got %h want flags 111 %h",
                 i, got_q[i], want_q[i]);
      end
    end
    checks++;
    if (fd_seen != 3 || rdy_mis != 0) begin
      errors++;
      $display("FAIL unit_fd got fd=%0d rdy_mis=%0d want 3 0",
               fd_seen, rdy_mis);
    end
  endtask

  task automatic test_cfg_err();
    int guard;
    logic [2:0] exf;
    cfg_width = 12'd0;
    cfg_height = 12'd2;
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_pixel = 24'h0000aa;
    repeat (2) cyc();
    checks++;
    if (cfg_err !== 1'b1 || in_ready !== 1'b0 || pushes != 0) begin
      errors++;
      $display("FAIL cfgerr_stall got err=%b rdy=%b push=%0d want 1 0 0",
               cfg_err, in_ready, pushes);
    end
    cfg_width = 12'd3;
    cyc();
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL cfgerr_clear got %b want 0", cfg_err);
    end
    guard = 0;
    while (pops < 6 && guard < 100) begin
      in_valid = (pushes < 6);
      in_pixel = 24'($urandom);
      if (pushes >= 2) begin
        cfg_width = 12'd9;
        cfg_height = 12'd9;
      end
      cyc();
      guard++;
    end
    in_valid = 1'b0;
    cyc();
    checks++;
    if (got_q.size() != 6) begin
      errors++; $display("FAIL cfgerr_count got %0d want 6", got_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        exf = {i == 5, i % 3 == 2, i == 0};
        checks++;
        if (got_q[i][26:24] !== exf || got_q[i] !== want_q[i]) begin
          errors++;
          $display("FAIL cfgerr_entry%0d got %h want flags %b", i,
                   got_q[i], exf);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    cfg_width = 12'd8;
    cfg_height = 12'd4;
    do_reset();
    out_ready = 1'b0;
    guard = 0;
    while (pushes < 5 && guard < 50) begin
      in_valid = 1'b1;
      in_pixel = 24'($urandom);
      cyc();
      guard++;
    end
    in_valid = 1'b0;
    checks++;
    if (level !== 5'd5) begin
      errors++; $display("FAIL midrst_pre got %0d want 5", level);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (level !== 5'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear got lvl=%0d v=%b want 0 0",
               level, out_valid);
    end
    reset = 1'b0;
    clear_model();
    cfg_width = 12'd2;
    cfg_height = 12'd2;
    out_ready = 1'b1;
    guard = 0;
    while (pops < 1 && guard < 50) begin
      in_valid = (pushes < 1);
      in_pixel = 24'h00c0de;
      cyc();
      guard++;
    end
    in_valid = 1'b0;
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL midrst_count got %0d want 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {3'b001, 24'h00c0de}) begin
        errors++;
        $display("FAIL midrst_sof got %h want %h", got_q[0],
                 {3'b001, 24'h00c0de});
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_pixel = '0;
    cfg_width = '0;
    cfg_height = '0;
    clear_model();
    test_reset();
    test_basic();
    test_full();
    test_random();
    test_unit_frame();
    test_cfg_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
